// File: rtl/counter_univ_n_pkg.sv
// Shared definitions for the universal counter family: mode constants,
// the per-edge operation encoding and the priority decode helper.
package counter_univ_n_pkg;

  // Limit behaviour selectors for the SATURATE parameter
  localparam bit CNT_MODE_WRAP = 1'b0;
  localparam bit CNT_MODE_SAT  = 1'b1;

  // Operation applied to the count register on a given edge (reset aside)
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLR   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } cnt_op_e;

  // Functional priority: clr > load > en; nothing asserted means hold
  function automatic cnt_op_e sel_op(input logic clr, input logic load, input logic en);
    if (clr) begin
      return OP_CLR;
    end
    if (load) begin
      return OP_LOAD;
    end
    if (en) begin
      return OP_COUNT;
    end
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational successor of the count and limit-event decode.
// The limit is detected against MOD-1 / 0 so MOD == 2**WIDTH needs no
// WIDTH+1-bit constant on the compare side.
module counter_next_val
  import counter_univ_n_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MOD      = 256,
  parameter bit              SATURATE = CNT_MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] q_next,
  output logic             limit
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           unused_carry;

  // Steps are taken one bit wider; away from a limit the top bit stays clear
  assign inc_ext      = {1'b0, q} + ONE_X;
  assign dec_ext      = {1'b0, q} - ONE_X;
  assign unused_carry = inc_ext[WIDTH] ^ dec_ext[WIDTH];

  // Select the next value and flag a wrap/saturation event at either limit
  always_comb begin
    q_next = q;
    limit  = 1'b0;
    if (up) begin
      if (q == MAX_Q) begin
        limit  = 1'b1;
        q_next = (SATURATE == CNT_MODE_SAT) ? MAX_Q : '0;
      end else begin
        q_next = inc_ext[WIDTH-1:0];
      end
    end else begin
      if (q == '0) begin
        limit  = 1'b1;
        q_next = (SATURATE == CNT_MODE_SAT) ? '0 : MAX_Q;
      end else begin
        q_next = dec_ext[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/counter_univ_n.sv
// Universal binary counter: configurable width/modulus, up/down, parallel
// load with clamp, sync clear, wrap or saturate, tick flags and a
// registered one-cycle wrap pulse.
module counter_univ_n
  import counter_univ_n_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MOD       = 256,
  parameter bit              SATURATE  = CNT_MODE_WRAP,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             max_tick,
  output logic             min_tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  // Refuse to build with a modulus or reset value the counter cannot hold
  if (WIDTH < 1 || WIDTH > 32 || MOD < 64'd2 || MOD > (64'd1 << WIDTH) ||
      RESET_VAL >= MOD) begin : g_param_err
    $error("counter_univ_n: illegal WIDTH/MOD/RESET_VAL combination");
  end

  logic [WIDTH-1:0] q_next;
  logic             limit;
  logic [WIDTH-1:0] d_clamped;
  cnt_op_e          op;

  counter_next_val #(
    .WIDTH    (WIDTH),
    .MOD      (MOD),
    .SATURATE (SATURATE)
  ) u_next (
    .q      (q),
    .up     (up),
    .q_next (q_next),
    .limit  (limit)
  );

  // Out-of-range load values land on the top of the count range
  assign d_clamped = (d > MAX_Q) ? MAX_Q : d;
  assign op        = sel_op(clr, load, en);

  // Count register and wrap pulse: reset first, then clr > load > en
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      unique case (op)
        OP_CLR: begin
          q    <= RST_Q;
          wrap <= 1'b0;
        end
        OP_LOAD: begin
          q    <= d_clamped;
          wrap <= 1'b0;
        end
        OP_COUNT: begin
          q    <= q_next;
          wrap <= limit;
        end
        default: begin
          wrap <= 1'b0;
        end
      endcase
    end
  end

  assign max_tick = (q == MAX_Q);
  assign min_tick = (q == '0);

endmodule
